alu_seq_core: RTL and testbench



---
 rtl/alu_seq_core_if.sv | 25 ++
 rtl/alu_seq_core.sv | 125 ++++++++++++
 tb/tb_alu_seq_core.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_core_if.sv
// Start/done bus between the multi-cycle controller (master) and alu_seq_core (slave).
// The Ovf signal exists only when ALU_OVF_EN is defined.
interface alu_seq_core_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             Start;
  logic [3:0]       AluCtl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [SHW-1:0]   Shamt;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Busy;
  logic             Done;
`ifdef ALU_OVF_EN
  logic             Ovf;

  modport master (output Start, AluCtl, A, B, Shamt, input Result, Zero, Busy, Done, Ovf);
  modport slave  (input Start, AluCtl, A, B, Shamt, output Result, Zero, Busy, Done, Ovf);
`else
  modport master (output Start, AluCtl, A, B, Shamt, input Result, Zero, Busy, Done);
  modport slave  (input Start, AluCtl, A, B, Shamt, output Result, Zero, Busy, Done);
`endif
endinterface

// File: rtl/alu_seq_core.sv
// Multi-cycle ALU: AND/OR/ADD/SUB/SLT in one cycle, SLL one bit per cycle.
// Define ALU_OVF_EN to add the registered signed-overflow output Ovf.
module alu_seq_core #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic           clk,
  input logic           rst,
  alu_seq_core_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1010;

  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_shl;
  logic             w_go_shift;

  assign w_sum      = bus.A + bus.B;
  assign w_diff     = bus.A - bus.B;
  assign w_slt      = $signed(bus.A) < $signed(bus.B);
  assign w_shl      = r_shreg << 1;
  assign w_go_shift = (bus.AluCtl == OP_SLL) && (bus.Shamt != '0);

  // SLL only reaches this path with Shamt=0, so its result is B unchanged.
  always_comb begin
    w_alu_res = '0;
    case (bus.AluCtl)
      OP_AND:  w_alu_res = bus.A & bus.B;
      OP_OR:   w_alu_res = bus.A | bus.B;
      OP_ADD:  w_alu_res = w_sum;
      OP_SUB:  w_alu_res = w_diff;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SLL:  w_alu_res = bus.B;
      default: w_alu_res = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  logic r_ovf;
  logic w_ovf;

  always_comb begin
    w_ovf = 1'b0;
    case (bus.AluCtl)
      OP_ADD:  w_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
      OP_SUB:  w_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (w_diff[WIDTH-1] != bus.A[WIDTH-1]);
      default: w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_IDLE && bus.Start) begin
      r_ovf <= w_go_shift ? 1'b0 : w_ovf;
    end
  end

  assign bus.Ovf = r_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.Start) begin
            if (w_go_shift) begin
              r_state <= ST_SHIFT;
              r_shreg <= bus.B;
              r_cnt   <= bus.Shamt;
            end else begin
              r_state  <= ST_DONE;
              r_result <= w_alu_res;
              r_zero   <= (w_alu_res == '0);
            end
          end
        end
        ST_SHIFT: begin
          // The last shift goes straight into Result so it lands on DONE entry.
          if (r_cnt == CNT_ONE) begin
            r_state  <= ST_DONE;
            r_result <= w_shl;
            r_zero   <= (w_shl == '0);
            r_cnt    <= '0;
          end else begin
            r_shreg <= w_shl;
            r_cnt   <= r_cnt - CNT_ONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Result = r_result;
  assign bus.Zero   = r_zero;
  assign bus.Busy   = (r_state != ST_IDLE);
  assign bus.Done   = (r_state == ST_DONE);
endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core; define ALU_OVF_EN to also exercise the overflow flag.
module tb_alu_seq_core;
  localparam int W = 32;
  localparam int S = 5;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_SLL = 4'b1010;
  localparam logic [3:0] C_BAD = 4'b0101;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  always #5 clk = ~clk;

  alu_seq_core_if #(.WIDTH(W), .SHW(S)) bus ();
  alu_seq_core #(.WIDTH(W), .SHW(S)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive Start for one edge, then scramble the operands; returns in the cycle after that edge.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [S-1:0] sh);
    bus.AluCtl = c; bus.A = a; bus.B = b; bus.Shamt = sh; bus.Start = 1'b1;
    step();
    bus.Start = 1'b0; bus.A = 32'hDEAD_BEEF; bus.B = 32'h1234_5678; bus.Shamt = 5'd7; bus.AluCtl = 4'b0001;
    $display("op ctl=%b a=%h b=%h sh=%0d -> result=%h zero=%b done=%b", c, a, b, sh,
             bus.Result, bus.Zero, bus.Done);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.Start = 1'b0; bus.AluCtl = '0; bus.A = '0; bus.B = '0; bus.Shamt = '0;
    step(); step();
    chk_cnt++; if (bus.Result !== 32'h0) $display("FAIL reset_result got=%h exp=0", bus.Result); else pass_cnt++;
    chk_cnt++; if (bus.Zero !== 1'b1) $display("FAIL reset_zero got=%b exp=1", bus.Zero); else pass_cnt++;
    chk_cnt++; if (bus.Busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.Busy); else pass_cnt++;
    chk_cnt++; if (bus.Done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.Done); else pass_cnt++;
`ifdef ALU_OVF_EN
    chk_cnt++; if (bus.Ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", bus.Ovf); else pass_cnt++;
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    issue(C_ADD, 32'd5, 32'd7, 5'd0);
    chk_cnt++; if (bus.Done !== 1'b1) $display("FAIL add_done got=%b exp=1", bus.Done); else pass_cnt++;
    chk_cnt++; if (bus.Busy !== 1'b1) $display("FAIL add_busy got=%b exp=1", bus.Busy); else pass_cnt++;
    chk_cnt++; if (bus.Result !== 32'd12) $display("FAIL add_result got=%h exp=c", bus.Result); else pass_cnt++;
    chk_cnt++; if (bus.Zero !== 1'b0) $display("FAIL add_zero got=%b exp=0", bus.Zero); else pass_cnt++;
    step();
    chk_cnt++; if (bus.Busy !== 1'b0) $display("FAIL add_busy_after got=%b exp=0", bus.Busy); else pass_cnt++;
    chk_cnt++; if (bus.Done !== 1'b0) $display("FAIL add_done_after got=%b exp=0", bus.Done); else pass_cnt++;
  endtask

  task automatic test_sub();
    issue(C_SUB, 32'd5, 32'd5, 5'd0);
    chk_cnt++; if (bus.Result !== 32'd0) $display("FAIL sub_result got=%h exp=0", bus.Result); else pass_cnt++;
    chk_cnt++; if (bus.Zero !== 1'b1) $display("FAIL sub_zero got=%b exp=1", bus.Zero); else pass_cnt++;
    step();
  endtask

  task automatic test_slt();
    issue(C_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
    chk_cnt++; if (bus.Result !== 32'd1) $display("FAIL slt_neg_result got=%h exp=1", bus.Result); else pass_cnt++;
    step();
    issue(C_SLT, 32'd1, 32'hFFFF_FFFF, 5'd0);
    chk_cnt++; if (bus.Result !== 32'd0) $display("FAIL slt_pos_result got=%h exp=0", bus.Result); else pass_cnt++;
    chk_cnt++; if (bus.Zero !== 1'b1) $display("FAIL slt_pos_zero got=%b exp=1", bus.Zero); else pass_cnt++;
    step();
  endtask

  task automatic test_sll_zero();
    issue(C_SLL, 32'h0, 32'h0000_ABCD, 5'd0);
    chk_cnt++; if (bus.Done !== 1'b1) $display("FAIL sll0_done got=%b exp=1", bus.Done); else pass_cnt++;
    chk_cnt++; if (bus.Result !== 32'h0000_ABCD) $display("FAIL sll0_result got=%h exp=abcd", bus.Result); else pass_cnt++;
    step();
  endtask

  // SLL by 4 with Start pulses landing on edges N+2 and N+5; Done only in cycle N+5.
  task automatic test_sll_busy();
    logic [W-1:0] exp_res;
    issue(C_SLL, 32'h0, 32'h1, 5'd4);
    bus.AluCtl = C_ADD; bus.A = 32'd1; bus.B = 32'd1;
    for (int c = 1; c <= 6; c++) begin
      exp_res = (c >= 5) ? 32'h10 : 32'h0000_ABCD;
      chk_cnt++; if (bus.Done !== (c == 5)) $display("FAIL sll4_done cyc=%0d got=%b exp=%b", c, bus.Done, c == 5); else pass_cnt++;
      chk_cnt++; if (bus.Result !== exp_res) $display("FAIL sll4_result cyc=%0d got=%h exp=%h", c, bus.Result, exp_res); else pass_cnt++;
      chk_cnt++; if (bus.Busy !== (c <= 5)) $display("FAIL sll4_busy cyc=%0d got=%b exp=%b", c, bus.Busy, c <= 5); else pass_cnt++;
      bus.Start = (c == 1 || c == 4);
      step();
    end
    bus.Start = 1'b0;
  endtask

  task automatic test_unknown();
    issue(C_BAD, 32'hFFFF_0000, 32'h0000_FFFF, 5'd0);
    chk_cnt++; if (bus.Result !== 32'h0) $display("FAIL bad_result got=%h exp=0", bus.Result); else pass_cnt++;
    chk_cnt++; if (bus.Zero !== 1'b1) $display("FAIL bad_zero got=%b exp=1", bus.Zero); else pass_cnt++;
    step();
  endtask

  // Start held through the DONE cycle is ignored there and taken once back in IDLE.
  task automatic test_back_to_back();
    issue(C_ADD, 32'd1, 32'd2, 5'd0);
    bus.AluCtl = C_ADD; bus.A = 32'd3; bus.B = 32'd4; bus.Start = 1'b1;
    chk_cnt++; if (bus.Result !== 32'd3) $display("FAIL b2b_first got=%h exp=3", bus.Result); else pass_cnt++;
    step();
    chk_cnt++; if (bus.Done !== 1'b0) $display("FAIL b2b_ignored_done got=%b exp=0", bus.Done); else pass_cnt++;
    chk_cnt++; if (bus.Result !== 32'd3) $display("FAIL b2b_hold got=%h exp=3", bus.Result); else pass_cnt++;
    step();
    bus.Start = 1'b0;
    chk_cnt++; if (bus.Done !== 1'b1) $display("FAIL b2b_second_done got=%b exp=1", bus.Done); else pass_cnt++;
    chk_cnt++; if (bus.Result !== 32'd7) $display("FAIL b2b_second got=%h exp=7", bus.Result); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_midflight();
    int done_seen = 0;
    issue(C_SLL, 32'h0, 32'h1, 5'd31);
    for (int i = 0; i < 9; i++) step();
    chk_cnt++; if (bus.Busy !== 1'b1) $display("FAIL midrst_busy_before got=%b exp=1", bus.Busy); else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++; if (bus.Busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", bus.Busy); else pass_cnt++;
    chk_cnt++; if (bus.Result !== 32'h0) $display("FAIL midrst_result got=%h exp=0", bus.Result); else pass_cnt++;
    chk_cnt++; if (bus.Zero !== 1'b1) $display("FAIL midrst_zero got=%b exp=1", bus.Zero); else pass_cnt++;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done === 1'b1) done_seen++;
      step();
    end
    chk_cnt++; if (done_seen !== 0) $display("FAIL midrst_no_done got=%0d pulses exp=0", done_seen); else pass_cnt++;
    $display("op reset mid-shift -> result=%h zero=%b busy=%b", bus.Result, bus.Zero, bus.Busy);
  endtask

`ifdef ALU_OVF_EN
  task automatic test_ovf();
    issue(C_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
    chk_cnt++; if (bus.Ovf !== 1'b1) $display("FAIL ovf_add got=%b exp=1", bus.Ovf); else pass_cnt++;
    chk_cnt++; if (bus.Result !== 32'h8000_0000) $display("FAIL ovf_add_result got=%h exp=80000000", bus.Result); else pass_cnt++;
    step();
    issue(C_SUB, 32'h8000_0000, 32'h1, 5'd0);
    chk_cnt++; if (bus.Ovf !== 1'b1) $display("FAIL ovf_sub got=%b exp=1", bus.Ovf); else pass_cnt++;
    chk_cnt++; if (bus.Result !== 32'h7FFF_FFFF) $display("FAIL ovf_sub_result got=%h exp=7fffffff", bus.Result); else pass_cnt++;
    step();
    issue(C_AND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    chk_cnt++; if (bus.Ovf !== 1'b0) $display("FAIL ovf_and got=%b exp=0", bus.Ovf); else pass_cnt++;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_sll_zero();
    test_sll_busy();
    test_unknown();
    test_back_to_back();
    test_reset_midflight();
`ifdef ALU_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
